// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and encodings for the pipeline hazard controller
package pipe_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } pipe_state_e;

    localparam logic [1:0] FWD_NONE        = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - EX operand forwarding select for one source register
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_m,
    input  logic       reg_write_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_w,
    output logic [1:0] fwd
);

    // MEM holds the younger result, so it wins over WB; x0 is never a source.
    always_comb begin
        fwd = FWD_NONE;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush/forward controller; PIPE_CTRL_PERF_EN adds perf counters
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic             RegWriteM,
    input  logic             MemAccessM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteW,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

    pipe_state_e state, state_nxt;
    logic        running;
    logic        mem_stall;
    logic        lw_stall;
    logic [1:0]  fwd_a, fwd_b;

    hazard_fwd_unit u_fwd_a (
        .rs          (Rs1E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_a)
    );

    hazard_fwd_unit u_fwd_b (
        .rs          (Rs2E),
        .rd_m        (RdM),
        .reg_write_m (RegWriteM),
        .rd_w        (RdW),
        .reg_write_w (RegWriteW),
        .fwd         (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        running   = rst_n && (state != BOOT);
        mem_stall = running && MemAccessM && !dmem_ready;
        lw_stall  = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

        state_nxt = state;
        case (state)
            BOOT:     state_nxt = RUN;
            RUN:      if (MemAccessM && !dmem_ready) state_nxt = MEM_WAIT;
            // Dropping MemAccessM while waiting is illegal; recover to RUN.
            MEM_WAIT: if (dmem_ready || !MemAccessM) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase

        dmem_req  = 1'b0;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;

        if (running) begin
            dmem_req  = MemAccessM;
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                // Freeze everything; redirects and bubbles wait for release.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushD = 1'b0;
                FlushE = 1'b0;
                FlushW = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall | PCSrcE;
                FlushW = 1'b0;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles    <= '0;
            flush_events    <= '0;
            mem_wait_cycles <= '0;
        end else begin
            if (StallF | StallM)               stall_cycles    <= stall_cycles + CNT_W'(1);
            if (running && PCSrcE && !mem_stall) flush_events  <= flush_events + CNT_W'(1);
            if (mem_stall)                     mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
        end
    end
`else
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl; honours PIPE_CTRL_PERF_EN
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic PCSrcE, RegWriteM, MemAccessM, RegWriteW, dmem_ready;
    logic dmem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemAccessM(MemAccessM),
        .RdW(RdW), .RegWriteW(RegWriteW), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE)
`ifdef PIPE_CTRL_PERF_EN
        , .stall_cycles(stall_cycles), .flush_events(flush_events), .mem_wait_cycles(mem_wait_cycles)
`endif
    );

    wire [11:0] act = {dmem_req, StallF, StallD, StallE, StallM,
                       FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

    int n_cmp = 0;
    int n_bad = 0;

    bit boot_q = 1'b1;
    bit wait_q = 1'b0;
    logic [CNT_W-1:0] m_stall = '0, m_flush = '0, m_wait = '0;

    function automatic logic [1:0] ref_fwd(logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit ref_mem_stall();
        return MemAccessM && !dmem_ready;
    endfunction

    // Expected {dmem_req, StallF..M, FlushD/E/W, ForwardAE, ForwardBE}.
    function automatic logic [11:0] ref_out();
        bit lu;
        logic [1:0] fa, fb;
        if (!rst_n || boot_q) return 12'b0_0000_111_0000;
        fa = ref_fwd(Rs1E);
        fb = ref_fwd(Rs2E);
        lu = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
        if (ref_mem_stall()) return {1'b1, 4'b1111, 3'b001, fa, fb};
        return {MemAccessM, lu, lu, 2'b00, PCSrcE, lu | PCSrcE, 1'b0, fa, fb};
    endfunction

    task automatic idle_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        ResultSrcE = 2'b00;
        {PCSrcE, RegWriteM, MemAccessM, RegWriteW, dmem_ready} = '0;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        logic [11:0] e;
        @(posedge clk);
        e = ref_out();
        if (!rst_n) begin
            boot_q = 1'b1;
            wait_q = 1'b0;
            m_stall = '0;
            m_flush = '0;
            m_wait = '0;
        end else if (boot_q) begin
            boot_q = 1'b0;
        end else begin
            if (wait_q && !MemAccessM) $display("note: illegal MEM_WAIT with MemAccessM=0 at %0t", $time);
            if (e[10] | e[7]) m_stall = m_stall + 1;
            if (PCSrcE && !ref_mem_stall()) m_flush = m_flush + 1;
            if (ref_mem_stall()) m_wait = m_wait + 1;
            wait_q = ref_mem_stall();
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++;
            if (act !== 12'b0_0000_111_0000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, act, 12'b0_0000_111_0000);
            end
            advance();
        end
        rst_n = 1'b1;
        sample();
        n_cmp++;
        if (act !== 12'b0_0000_111_0000) begin
            n_bad++;
            $display("FAIL boot_cycle: got %b want %b", act, 12'b0_0000_111_0000);
        end
        advance();
        sample();
        n_cmp++;
        if (act !== 12'b0) begin
            n_bad++;
            $display("FAIL run_idle: got %b want %b", act, 12'b0);
        end
        advance();
    endtask

    task automatic test_load_use();
        idle_inputs();
        ResultSrcE = 2'b01; RdE = 5'd5; Rs2D = 5'd5; Rs1D = 5'd3;
        sample();
        n_cmp++;
        if ({StallF, StallD, FlushE, FlushD, StallE} !== 5'b11100) begin
            n_bad++;
            $display("FAIL load_use: got %b want %b", {StallF, StallD, FlushE, FlushD, StallE}, 5'b11100);
        end
        advance();
        RdE = 5'd0; Rs2D = 5'd0;
        sample();
        n_cmp++;
        if (act !== ref_out() || StallF !== 1'b0) begin
            n_bad++;
            $display("FAIL load_use_x0: got %b want %b", act, ref_out());
        end
        advance();
    endtask

    task automatic test_forward();
        idle_inputs();
        RdM = 5'd7; RdW = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7; RegWriteM = 1'b1; RegWriteW = 1'b1;
        sample();
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b1010) begin
            n_bad++;
            $display("FAIL fwd_mem_prio: got %b want %b", {ForwardAE, ForwardBE}, 4'b1010);
        end
        advance();
        RdM = 5'd0;
        sample();
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0101) begin
            n_bad++;
            $display("FAIL fwd_wb: got %b want %b", {ForwardAE, ForwardBE}, 4'b0101);
        end
        advance();
        RdW = 5'd0; Rs1E = 5'd0;
        sample();
        n_cmp++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin
            n_bad++;
            $display("FAIL fwd_none: got %b want %b", {ForwardAE, ForwardBE}, 4'b0000);
        end
        advance();
    endtask

    task automatic test_mem_wait();
        int stalled = 0;
        logic [CNT_W-1:0] w0 = m_wait;
        idle_inputs();
        MemAccessM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 3);
            sample();
            if ({StallF, StallD, StallE, StallM, FlushW} === 5'b11111) stalled++;
            n_cmp++;
            if (act !== ref_out()) begin
                n_bad++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, act, ref_out());
            end
            advance();
        end
        idle_inputs();
        n_cmp++;
        if (stalled != 3) begin
            n_bad++;
            $display("FAIL mem_wait_len: got %0d want 3", stalled);
        end
`ifdef PIPE_CTRL_PERF_EN
        sample();
        n_cmp++;
        if (mem_wait_cycles !== w0 + 3) begin
            n_bad++;
            $display("FAIL mem_wait_cnt: got %0d want %0d", mem_wait_cycles, w0 + 3);
        end
`else
        w0 = '0;
`endif
        advance();
    endtask

    task automatic test_branch_mem_wait();
        int fl = 0;
        idle_inputs();
        MemAccessM = 1'b1; PCSrcE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dmem_ready = (i == 2);
            if (i == 3) begin MemAccessM = 1'b0; PCSrcE = 1'b0; end
            sample();
            if (FlushD === 1'b1 && FlushE === 1'b1) fl++;
            n_cmp++;
            if (i < 2 && {FlushD, FlushE} !== 2'b00) begin
                n_bad++;
                $display("FAIL branch_in_wait[%0d]: got %b want 00", i, {FlushD, FlushE});
            end else if (i == 2 && {FlushD, FlushE} !== 2'b11) begin
                n_bad++;
                $display("FAIL branch_release: got %b want 11", {FlushD, FlushE});
            end else if (act !== ref_out()) begin
                n_bad++;
                $display("FAIL branch_wait_model[%0d]: got %b want %b", i, act, ref_out());
            end
            advance();
        end
        n_cmp++;
        if (fl != 1) begin
            n_bad++;
            $display("FAIL branch_flush_len: got %0d want 1", fl);
        end
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        MemAccessM = 1'b1;
        sample();
        advance();
        rst_n = 1'b0;
        sample();
        n_cmp++;
        if (dmem_req !== 1'b0 || act !== 12'b0_0000_111_0000) begin
            n_bad++;
            $display("FAIL rst_mid_wait: got %b want %b", act, 12'b0_0000_111_0000);
        end
        advance();
        rst_n = 1'b1;
        sample();
        n_cmp++;
        if (act !== 12'b0_0000_111_0000) begin
            n_bad++;
            $display("FAIL rst_mid_wait_boot: got %b want %b", act, 12'b0_0000_111_0000);
        end
        advance();
        sample();
        n_cmp++;
        if (act !== ref_out() || StallM !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_wait_rerun: got %b want %b", act, ref_out());
        end
        advance();
        idle_inputs();
        sample();
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            ResultSrcE = 2'($urandom_range(0, 3));
            PCSrcE     = ($urandom_range(0, 4) == 0);
            RegWriteM  = 1'($urandom);
            RegWriteW  = 1'($urandom);
            MemAccessM = wait_q ? 1'b1 : ($urandom_range(0, 2) == 0);
            dmem_ready = 1'($urandom);
            sample();
            n_cmp++;
            if (act !== ref_out()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %b want %b", i, act, ref_out());
            end
            advance();
        end
        idle_inputs();
        sample();
        advance();
    endtask

    task automatic test_perf();
`ifdef PIPE_CTRL_PERF_EN
        sample();
        n_cmp++;
        if ({stall_cycles, flush_events, mem_wait_cycles} !== {m_stall, m_flush, m_wait}) begin
            n_bad++;
            $display("FAIL perf_counters: got %0d/%0d/%0d want %0d/%0d/%0d",
                     stall_cycles, flush_events, mem_wait_cycles, m_stall, m_flush, m_wait);
        end
        advance();
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_mem_wait();
        test_branch_mem_wait();
        test_reset_mid_wait();
        test_random();
        test_perf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Hazard and sequencing controller for the five-stage RV64 pipeline. Drives stall, flush and forwarding controls into the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX operand muxes. Detects load-use and control hazards, holds the whole pipeline across multi-cycle data-memory accesses through a req/ready handshake, and inserts one boot bubble after reset. Sits beside the datapath; it contains no datapath registers of its own.

## Interface
- Parameters: `CNT_W`, default 32, width of the performance counters (used only with `PIPE_CTRL_PERF_EN`).
- Reset: one clock, synchronous active-low reset.
- `clk  in  1`: core clock; all state updates on its rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `Rs1D`, `Rs2D`  in  5 each: source registers in the decode stage.
- `Rs1E`, `Rs2E`, `RdE`  in  5 each: source and destination registers held in ID/EX.
- `ResultSrcE`  in  2: value `2'b01` marks a load in EX.
- `PCSrcE`  in  1: branch taken or jump resolved in EX.
- `RdM`, `RegWriteM`  in  5/1: destination and write enable in MEM.
- `MemAccessM`  in  1: load or store present in MEM.
- `RdW`, `RegWriteW`  in  5/1: destination and write enable in WB.
- `dmem_ready`  in  1: data memory completes the access this cycle.
- `dmem_req`  out  1: data-memory request.
- `StallF`, `StallD`, `StallE`, `StallM`  out  1 each: hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- `FlushD`, `FlushE`, `FlushW`  out  1 each: clear the IF/ID, ID/EX and MEM/WB registers.
- `ForwardAE`, `ForwardBE`  out  2 each: operand mux select for EX.
- `stall_cycles`, `flush_events`, `mem_wait_cycles`  out  CNT_W each: present only with `PIPE_CTRL_PERF_EN`.

## Operation
- The FSM has three states: BOOT, RUN and MEM_WAIT.
- rst_n=0 sets the state to BOOT at the next edge.
  - While rst_n=0 or in BOOT: FlushD=FlushE=FlushW=1, every Stall=0, dmem_req=0, Forward=00.
- BOOT→RUN is unconditional after one cycle.
- RUN→MEM_WAIT when MemAccessM && !dmem_ready.
- MEM_WAIT→RUN when dmem_ready.
- dmem_req = MemAccessM in RUN and MEM_WAIT.
  - A same-cycle dmem_ready is a zero-wait access with no stall.
- memStall = MemAccessM && !dmem_ready, in RUN or MEM_WAIT.
  - Forces StallF=StallD=StallE=StallM=1 and FlushW=1.
  - Forces FlushD=FlushE=0. A pending PCSrcE or load-use takes effect on the first cycle after release.
- lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). Effective only when !memStall.
- Hazard outputs when !memStall:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
  - StallE = StallM = FlushW = 0.
- If PCSrcE and lwStall occur together, both flushes are applied. StallF is still asserted; the redirect PC load has priority over StallF in the fetch mux.
- Forwarding for A (B is identical using Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - MEM takes priority over WB. x0 is never forwarded.
- A MEM_WAIT state with MemAccessM=0 is illegal. The bench flags it; the RTL returns to RUN.

## Timing
- All control outputs are combinational from state and inputs, so they take effect at the next edge.
- The FSM and counters are registered.
- A load-use hazard costs exactly 1 bubble. A taken branch or jump costs 2 squashed instructions.
- A memory access with N wait cycles stalls F/D/E/M for exactly N cycles.
- Reset asserted mid-MEM_WAIT returns to BOOT at the next edge. dmem_req drops in the same cycle rst_n is low.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cycles` increments on any cycle with StallF|StallM.
  - `flush_events` increments on any cycle with PCSrcE && !memStall.
  - `mem_wait_cycles` increments on any cycle with memStall.
  - All counters wrap modulo 2^CNT_W and clear on reset.
- Not defined: counter ports and registers are absent; control behaviour is identical.

## Structure
- `pipe_pkg` holds:
  - the state enum (BOOT, RUN, MEM_WAIT);
  - the forward encodings FWD_NONE=00, FWD_WB=01, FWD_MEM=10;
  - RESULT_SRC_LOAD=2'b01.
- Sub-module `hazard_fwd_unit` contains the combinational forwarding compare for one operand and is instantiated twice.

## Test plan
- Reset release: rst_n low for 3 cycles, then high → FlushD/FlushE/FlushW=1 during reset and for 1 BOOT cycle, then all controls 0.
- Load-use: ResultSrcE=01, RdE=5, Rs2D=5 → StallF=StallD=FlushE=1 for 1 cycle. With RdE=0 → no stall.
- Forward priority: RdM=RdW=Rs1E=7, both RegWrite=1 → ForwardAE=10. With RdM=0 → 01.
- Memory wait: MemAccessM=1, dmem_ready low for 3 cycles → all Stall=1 and FlushW=1 for exactly 3 cycles, state MEM_WAIT, then RUN. `mem_wait_cycles`=3 when `PIPE_CTRL_PERF_EN` is defined.
- Branch during memory wait: PCSrcE=1 while memStall → FlushD=FlushE=0 until dmem_ready, then both 1 for 1 cycle.
- Reset mid-MEM_WAIT: rst_n=0 → dmem_req=0 in the same cycle, state BOOT next cycle.
